// File: rtl/dtu_param_if.sv
// dtu_param_if: control, character and serial-line bundle for the dtu_param transceiver
interface dtu_param_if #(
  parameter int DATA_W = 7,
  parameter int DIV_W = 16
);
  logic en;
  logic clk_div_ld;
  logic [DIV_W-1:0] clk_div_val;
  logic tx_start;
  logic [DATA_W-1:0] tx_data;
  logic tx_busy;
  logic txd;
  logic rxd;
  logic rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic rx_error;
  logic rx_ready;
  logic rx_busy;
  logic rx_overrun;
  modport master (
    output en, clk_div_ld, clk_div_val, tx_start, tx_data, rxd, rx_ack,
    input tx_busy, txd, rx_data, rx_error, rx_ready, rx_busy, rx_overrun
  );
  modport slave (
    input en, clk_div_ld, clk_div_val, tx_start, tx_data, rxd, rx_ack,
    output tx_busy, txd, rx_data, rx_error, rx_ready, rx_busy, rx_overrun
  );
endinterface

// File: rtl/dtu_param.sv
// dtu_param: parametrised serial transceiver with loadable bit divider and error-tagged RX FIFO
module dtu_param #(
  parameter int DATA_W = 7,
  parameter int PARITY = 1,
  parameter int STOP_BITS = 1,
  parameter int DIV_W = 16,
  parameter int DIV_RST = 15,
  parameter int RX_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dtu_param_if.slave bus
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [3:0] DLAST = 4'(DATA_W - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START_CHK, R_DATA, R_PAR, R_STOP, R_WAIT_HIGH} rx_st_t;
  tx_st_t tx_st;
  rx_st_t rx_st;
  logic [DIV_W-1:0] div_q, tx_p, tx_cnt, rx_p, rx_cnt;
  logic [3:0] tx_n, rx_n;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic tx_par, txd, tx_busy, rs1, rs2, rx_perr, rx_ferr, rx_busy;
  logic push, push_err, pop, full, empty, ovr;
  logic [DATA_W:0] mem [RX_DEPTH];
  logic [AW:0] wp, rp;
  function automatic logic par_of(input logic [DATA_W-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction
  always_ff @(posedge clk)
    div_q <= rst ? DIV_W'(DIV_RST) : bus.clk_div_ld ? bus.clk_div_val : div_q;
  always_ff @(posedge clk)
    if (rst || !bus.en) begin
      tx_st <= T_IDLE;
      txd <= 1'b1;
      tx_busy <= 1'b0;
    end else if (tx_st == T_IDLE) begin
      if (bus.tx_start) begin
        tx_st <= T_START;
        txd <= 1'b0;
        tx_busy <= 1'b1;
        tx_p <= div_q;
        tx_cnt <= div_q;
        tx_sh <= bus.tx_data;
        tx_par <= par_of(bus.tx_data);
        tx_n <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt <= tx_p;
      case (tx_st)
        T_START: begin
          tx_st <= T_DATA;
          txd <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        T_DATA:
          if (tx_n == DLAST) begin
            tx_st <= (PARITY != 0) ? T_PAR : T_STOP;
            txd <= (PARITY != 0) ? tx_par : 1'b1;
            tx_n <= '0;
          end else begin
            txd <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_n <= tx_n + 1'b1;
          end
        T_PAR: begin
          tx_st <= T_STOP;
          txd <= 1'b1;
        end
        default:
          if (tx_n == SLAST) begin
            tx_st <= T_IDLE;
            tx_busy <= 1'b0;
          end else begin
            tx_n <= tx_n + 1'b1;
          end
      endcase
    end
  always_ff @(posedge clk)
    {rs2, rs1} <= rst ? 2'b11 : {rs1, bus.rxd};
  always_ff @(posedge clk)
    if (rst || !bus.en) begin
      rx_st <= R_IDLE;
      rx_busy <= 1'b0;
    end else begin
      case (rx_st)
        R_IDLE:
          if (!rs2) begin
            rx_st <= R_START_CHK;
            rx_busy <= 1'b1;
            rx_p <= div_q;
            rx_cnt <= DIV_W'(({1'b0, div_q} + 1'b1) >> 1) - 1'b1;
          end
        R_WAIT_HIGH:
          if (rs2) rx_st <= R_IDLE;
        default:
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_cnt <= rx_p;
            case (rx_st)
              R_START_CHK:
                if (rs2) begin
                  rx_st <= R_IDLE;
                  rx_busy <= 1'b0;
                end else begin
                  rx_st <= R_DATA;
                  rx_n <= '0;
                  rx_perr <= 1'b0;
                  rx_ferr <= 1'b0;
                end
              R_DATA: begin
                rx_sh <= {rs2, rx_sh[DATA_W-1:1]};
                rx_n <= (rx_n == DLAST) ? '0 : rx_n + 1'b1;
                if (rx_n == DLAST) rx_st <= (PARITY != 0) ? R_PAR : R_STOP;
              end
              R_PAR: begin
                rx_perr <= rs2 != par_of(rx_sh);
                rx_st <= R_STOP;
              end
              default: begin
                rx_ferr <= rx_ferr | !rs2;
                rx_n <= rx_n + 1'b1;
                if (rx_n == SLAST) begin
                  rx_st <= (rx_ferr || !rs2) ? R_WAIT_HIGH : R_IDLE;
                  rx_busy <= 1'b0;
                end
              end
            endcase
          end
      endcase
    end
  assign push = bus.en && rx_st == R_STOP && rx_cnt == '0 && rx_n == SLAST;
  assign push_err = rx_perr | rx_ferr | !rs2;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop = bus.rx_ack && !empty;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ovr <= 1'b0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wp[AW-1:0]] <= {push_err, rx_sh};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      ovr <= pop ? 1'b0 : (push && full) ? 1'b1 : ovr;
    end
  assign {bus.rx_error, bus.rx_data} = empty ? '0 : mem[rp[AW-1:0]];
  assign bus.rx_ready = !empty;
  assign bus.rx_overrun = ovr;
  assign bus.rx_busy = rx_busy;
  assign bus.tx_busy = tx_busy;
  assign bus.txd = txd;
endmodule

// File: tb/tb_dtu_param.sv
// tb_dtu_param: randomized self-checking bench for dtu_param against a frame-level reference model
module tb_dtu_param;
  localparam int DW = 7;
  localparam int PAR = 1;
  localparam int SB = 1;
  localparam int DIVW = 16;
  localparam int DEPTH = 4;
  localparam int F = 1 + DW + (PAR != 0 ? 1 : 0) + SB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b0;
  logic rxd_drv = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [DW:0] mq [$];
  bit m_ovr = 0;
  int n, m;
  bit saw;
  int rp;
  logic [DW-1:0] rd;
  bit rbp;
  always #5 clk = ~clk;
  dtu_param_if #(.DATA_W(DW), .DIV_W(DIVW)) bus ();
  assign bus.rxd = loop ? bus.txd : rxd_drv;
  dtu_param #(
    .DATA_W(DW), .PARITY(PAR), .STOP_BITS(SB), .DIV_W(DIVW), .DIV_RST(15), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  function automatic logic pbit(input logic [DW-1:0] d);
    return (($countones(d) % 2) == 1) ^ (PAR == 2);
  endfunction
  function automatic logic fbit(input logic [DW-1:0] d, input bit bp, input bit bs, input int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return d[i-1];
    if (PAR != 0 && i == DW + 1) return pbit(d) ^ bp;
    return !bs;
  endfunction
  task automatic model_push(input logic [DW-1:0] d, input bit e);
    if (mq.size() < DEPTH) mq.push_back({e, d});
    else m_ovr = 1;
  endtask
  task automatic ld_div(input int v);
    bus.clk_div_val = DIVW'(v);
    bus.clk_div_ld = 1'b1;
    tick(1);
    bus.clk_div_ld = 1'b0;
  endtask
  task automatic send_rx(input logic [DW-1:0] d, input bit bp, input bit bs, input int p);
    for (int i = 0; i < F; i++) begin
      rxd_drv = fbit(d, bp, bs, i);
      tick(p);
    end
    if (bs) begin
      tick(20);
      chk("wait_high_idle", bus.rx_busy, 0);
    end
    rxd_drv = 1'b1;
    tick(4);
    model_push(d, bp | bs);
  endtask
  task automatic pop_chk(input string tag);
    chk({tag, "_ready"}, bus.rx_ready, mq.size() != 0);
    chk({tag, "_ovr"}, bus.rx_overrun, m_ovr);
    if (mq.size() != 0) begin
      chk({tag, "_data"}, bus.rx_data, mq[0][DW-1:0]);
      chk({tag, "_err"}, bus.rx_error, mq[0][DW]);
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      void'(mq.pop_front());
      m_ovr = 0;
    end
  endtask
  task automatic tx_len(input logic [DW-1:0] d, output int len);
    bus.tx_data = d;
    bus.tx_start = 1'b1;
    tick(1);
    bus.tx_start = 1'b0;
    len = 0;
    while (bus.tx_busy && len < 2000) begin
      tick(1);
      len++;
    end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.clk_div_ld = 1'b0;
    bus.clk_div_val = '0;
    bus.tx_start = 1'b0;
    bus.tx_data = '0;
    bus.rx_ack = 1'b0;
    tick(3);
    chk("rst_txd", bus.txd, 1);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_rx_busy", bus.rx_busy, 0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_rx_error", bus.rx_error, 0);
    chk("rst_rx_overrun", bus.rx_overrun, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    tick(1);
    tx_len(7'h12, n);
    chk("rst_div_len", n, F * 16);
    tick(2);
    ld_div(3);
    loop = 1'b1;
    bus.tx_data = 7'h41;
    bus.tx_start = 1'b1;
    tick(1);
    bus.tx_start = 1'b0;
    for (int i = 0; i < F * 4; i++) begin
      chk("lb_txd", bus.txd, fbit(7'h41, 0, 0, i / 4));
      chk("lb_busy", bus.tx_busy, 1);
      tick(1);
    end
    chk("lb_busy_end", bus.tx_busy, 0);
    tick(6);
    loop = 1'b0;
    model_push(7'h41, 0);
    pop_chk("lb");
    bus.tx_start = 1'b1;
    tick(1);
    n = 0;
    while (bus.tx_busy && n < 1000) begin
      tick(1);
      n++;
    end
    chk("hold_len", n, F * 4);
    m = 0;
    while (!bus.tx_busy && m < 10) begin
      tick(1);
      m++;
    end
    chk("hold_gap", m, 1);
    bus.tx_start = 1'b0;
    n = 0;
    while (bus.tx_busy && n < 1000) begin
      tick(1);
      n++;
    end
    tick(2);
    bus.tx_data = '0;
    bus.tx_start = 1'b1;
    tick(1);
    bus.tx_start = 1'b0;
    n = 0;
    while (bus.tx_busy && n < 500) begin
      bus.clk_div_val = 16'd7;
      bus.clk_div_ld = (n == 10);
      tick(1);
      n++;
    end
    bus.clk_div_ld = 1'b0;
    chk("reload_cur", n, F * 4);
    tx_len('0, n);
    chk("reload_next", n, F * 8);
    ld_div(3);
    send_rx(7'h41, 1, 0, 4);
    pop_chk("par_err");
    send_rx(7'h55, 0, 1, 4);
    pop_chk("frm_err");
    pop_chk("frm_single");
    rxd_drv = 1'b0;
    tick(1);
    rxd_drv = 1'b1;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      saw |= bus.rx_busy;
      tick(1);
    end
    chk("glitch_seen", saw, 1);
    chk("glitch_busy", bus.rx_busy, 0);
    chk("glitch_ready", bus.rx_ready, 0);
    for (int k = 1; k <= 5; k++) send_rx(DW'(k), 0, 0, 4);
    for (int k = 0; k < 5; k++) pop_chk("ovr");
    for (int k = 0; k < 12; k++) begin
      rp = $urandom_range(4, 8);
      rd = DW'($urandom);
      rbp = ($urandom_range(0, 3) == 0);
      ld_div(rp - 1);
      send_rx(rd, rbp, 0, rp);
      pop_chk("rnd_rx");
    end
    for (int k = 0; k < 6; k++) begin
      rp = $urandom_range(4, 6);
      rd = DW'($urandom);
      ld_div(rp - 1);
      loop = 1'b1;
      tx_len(rd, n);
      chk("rnd_lb_len", n, F * rp);
      tick(6);
      loop = 1'b0;
      model_push(rd, 0);
      pop_chk("rnd_lb");
    end
    ld_div(3);
    bus.tx_data = 7'h7F;
    bus.tx_start = 1'b1;
    tick(1);
    bus.tx_start = 1'b0;
    tick(12);
    bus.en = 1'b0;
    tick(1);
    chk("abort_txd", bus.txd, 1);
    chk("abort_tx_busy", bus.tx_busy, 0);
    bus.en = 1'b1;
    tick(2);
    chk("abort_tx_idle", bus.tx_busy, 0);
    send_rx(7'h2A, 0, 0, 4);
    rxd_drv = 1'b0;
    tick(10);
    bus.en = 1'b0;
    rxd_drv = 1'b1;
    tick(1);
    chk("en_rx_busy", bus.rx_busy, 0);
    tick(3);
    bus.en = 1'b1;
    tick(2);
    pop_chk("en_keep");
    send_rx(7'h33, 0, 0, 4);
    rxd_drv = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rxd_drv = 1'b1;
    mq.delete();
    m_ovr = 0;
    chk("rst_mid_busy", bus.rx_busy, 0);
    chk("rst_mid_ready", bus.rx_ready, 0);
    tick(4);
    pop_chk("rst_mid");
    tx_len(7'h01, n);
    chk("rst_mid_div", n, F * 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
